// File: rtl/rr_logb_packer.sv
// rr_logb_packer: buffers logged bus cycles as records and serializes
// each into a header beat plus the payload slices of its valid channels.
module rr_logb_packer #(
  parameter int NUM_CH          = 3,
  parameter int CH_W            = 40,
  parameter int LOGE_CNT        = 5,
  parameter int OUT_W           = 32,
  parameter int DEPTH           = 8,
  parameter int ALMFUL_LO_SLACK = 4,
  parameter int ALMFUL_HI_SLACK = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        logb_valid,
  input  logic [NUM_CH*CH_W-1:0]   logb_data,
  input  logic [LOGE_CNT-1:0]      loge_valid,
  output logic                     logb_almful_lo,
  output logic                     logb_almful_hi,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_last,
  output logic                     overflow
);

  localparam int BPC   = (CH_W + OUT_W - 1) / OUT_W;
  localparam int DW    = NUM_CH * CH_W;
  localparam int REC_W = LOGE_CNT + NUM_CH + DW;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW    = (BPC > 1) ? $clog2(BPC) : 1;

  generate
    if (OUT_W < NUM_CH + LOGE_CNT) begin : g_bad_out_w
      $error("OUT_W too narrow for header");
    end
    if (ALMFUL_HI_SLACK >= ALMFUL_LO_SLACK) begin : g_bad_slack
      $error("ALMFUL_HI_SLACK must be < ALMFUL_LO_SLACK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     ch, ch_n;
  logic [BW-1:0]     beat, beat_n;
  logic [REC_W-1:0]  cur, ld_rec;
  logic              load;
  logic [REC_W-1:0]  mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, nxt_ptr;
  logic [CW-1:0]     count, count_n;

  logic [REC_W-1:0]      in_rec;
  logic                  rec_arrive, full, push, pop, hs;
  logic [LOGE_CNT-1:0]   cur_loge;
  logic [NUM_CH-1:0]     cur_vld;
  logic [DW-1:0]         cur_data;
  logic [BPC*OUT_W-1:0]  pad;
  logic [OUT_W-1:0]      hdr;
  logic                  first_ok, nxt_ok;
  logic [IW-1:0]         first_idx, nxt_idx;

  assign in_rec     = {loge_valid, logb_valid, logb_data};
  assign rec_arrive = (|logb_valid) || (|loge_valid);
  assign full       = (count == CW'(DEPTH));
  assign push       = rec_arrive && !full;
  assign hs         = out_valid && out_ready;
  assign pop        = hs && out_last;
  assign nxt_ptr    = rd_ptr + PW'(1);

  assign cur_loge = cur[REC_W-1 -: LOGE_CNT];
  assign cur_vld  = cur[DW +: NUM_CH];
  assign cur_data = cur[DW-1:0];

  always_comb begin
    first_ok  = 1'b0;
    first_idx = '0;
    nxt_ok    = 1'b0;
    nxt_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cur_vld[i]) begin
        first_ok  = 1'b1;
        first_idx = IW'(i);
      end
      if (cur_vld[i] && (i > int'(ch))) begin
        nxt_ok  = 1'b1;
        nxt_idx = IW'(i);
      end
    end
  end

  always_comb begin
    hdr = '0;
    hdr[NUM_CH-1:0]          = cur_vld;
    hdr[NUM_CH +: LOGE_CNT]  = cur_loge;
    pad = '0;
    pad[CH_W-1:0] = cur_data[ch*CH_W +: CH_W];
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_comb begin
    state_n   = state;
    ch_n      = ch;
    beat_n    = beat;
    load      = 1'b0;
    ld_rec    = mem[rd_ptr];
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          state_n = HDR;
          load    = 1'b1;
        end else if (push) begin
          state_n = HDR;
          load    = 1'b1;
          ld_rec  = in_rec;
        end
      end
      HDR: begin
        out_valid = 1'b1;
        out_data  = hdr;
        out_last  = !first_ok;
        if (hs && first_ok) begin
          state_n = DATA;
          ch_n    = first_idx;
          beat_n  = '0;
        end
      end
      DATA: begin
        out_valid = 1'b1;
        out_data  = pad[beat*OUT_W +: OUT_W];
        out_last  = (beat == BW'(BPC - 1)) && !nxt_ok;
        if (hs && !out_last) begin
          if (beat != BW'(BPC - 1)) begin
            beat_n = beat + BW'(1);
          end else begin
            ch_n   = nxt_idx;
            beat_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // On the final beat, chain straight into the next record's header
    if (pop) begin
      if (count > CW'(1)) begin
        state_n = HDR;
        load    = 1'b1;
        ld_rec  = mem[nxt_ptr];
      end else if (push) begin
        state_n = HDR;
        load    = 1'b1;
        ld_rec  = in_rec;
      end else begin
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_rec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ch             <= '0;
      beat           <= '0;
      cur            <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      logb_almful_lo <= 1'b0;
      logb_almful_hi <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      state  <= state_n;
      ch     <= ch_n;
      beat   <= beat_n;
      count  <= count_n;
      if (load) cur <= ld_rec;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= nxt_ptr;
      logb_almful_lo <= (count_n >= CW'(DEPTH - ALMFUL_LO_SLACK));
      logb_almful_hi <= (count_n >= CW'(DEPTH - ALMFUL_HI_SLACK));
      if (rec_arrive && full) overflow <= 1'b1;
    end
  end

endmodule
